// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared DAC code width, code type, scheduler states and slew helper
// Used by dac_sample_fifo and dac_sample_sched (slew helper used under DAC_SLEW_LIMIT_EN).
package dac_pkg;

  localparam int DAC_W = 8;
  localparam int DAC_MAX = (1 << DAC_W) - 1;

  typedef logic [DAC_W-1:0] dac_code_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dac_state_t;

  // Move cur toward tgt by at most step, clamped to the DAC code range.
  function automatic dac_code_t slew_toward(input dac_code_t cur, input dac_code_t tgt,
                                            input int step);
    int c;
    int t;
    int n;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + step) begin
      n = c + step;
    end else if (t < c - step) begin
      n = c - step;
    end else begin
      n = t;
    end
    if (n > DAC_MAX) n = DAC_MAX;
    if (n < 0) n = 0;
    return dac_code_t'(n);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// rtl/dac_sample_fifo.sv - sample FIFO with registered level, full/empty and show-ahead head
// Full is derived from the registered level, so a same-cycle pop never frees a slot early.
module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  dac_code_t              push_data,
  input  logic                   pop,
  output dac_code_t              pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  dac_code_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dac_sample_sched.sv
// rtl/dac_sample_sched.sv - paced DAC sample scheduler: FIFO, rate divider, underrun flag
// Optional macro DAC_SLEW_LIMIT_EN limits each code change to SLEW_STEP.
module dac_sample_sched
  import dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int SLEW_STEP  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        EN,
  input  logic [DIV_W-1:0]            RATE_DIV,
  input  logic                        S_VALID,
  output logic                        S_READY,
  input  dac_code_t                   S_DATA,
  output dac_code_t                   DAC_CODE,
  output logic                        DAC_UPDATE,
  output logic                        UNDERRUN,
  input  logic                        CLR_UNDERRUN,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        BUSY
);

  dac_state_t       state;
  dac_state_t       state_next;
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic             pop;
  logic             full;
  logic             empty;
  dac_code_t        head;
  dac_code_t        code_next;

  dac_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (S_VALID),
    .push_data(S_DATA),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .level    (FIFO_LEVEL)
  );

  assign S_READY = !full;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!EN) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_PRIME;
        ST_PRIME: if (!empty) state_next = ST_RUN;
        ST_RUN:   state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY = (state == ST_RUN);
    tick = BUSY && (cnt >= RATE_DIV);
    pop  = tick && !empty;
  end

  // Counter only runs while RUN persists; entering or leaving RUN leaves it at zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (state == ST_RUN && state_next == ST_RUN) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

`ifdef DAC_SLEW_LIMIT_EN
  assign code_next = slew_toward(DAC_CODE, head, SLEW_STEP);
`else
  assign code_next = head;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DAC_CODE   <= '0;
      DAC_UPDATE <= 1'b0;
    end else begin
      DAC_UPDATE <= pop;
      if (pop) DAC_CODE <= code_next;
    end
  end

  // An underrun in the same cycle as a clear request keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      UNDERRUN <= 1'b0;
    end else if (tick && empty) begin
      UNDERRUN <= 1'b1;
    end else if (CLR_UNDERRUN) begin
      UNDERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_sample_sched.sv
// tb/tb_dac_sample_sched.sv - self-checking bench for dac_sample_sched against a queue-based model
// Honours DAC_SLEW_LIMIT_EN when the design is built with it.
module tb_dac_sample_sched;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
  localparam int STEP  = 16;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic [DIV_W-1:0] RATE_DIV;
  logic             S_VALID;
  logic             S_READY;
  logic [7:0]       S_DATA;
  logic [7:0]       DAC_CODE;
  logic             DAC_UPDATE;
  logic             UNDERRUN;
  logic             CLR_UNDERRUN;
  logic [3:0]       FIFO_LEVEL;
  logic             BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dac_sample_sched #(
    .FIFO_DEPTH(DEPTH),
    .DIV_W     (DIV_W),
    .SLEW_STEP (STEP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .RATE_DIV    (RATE_DIV),
    .S_VALID     (S_VALID),
    .S_READY     (S_READY),
    .S_DATA      (S_DATA),
    .DAC_CODE    (DAC_CODE),
    .DAC_UPDATE  (DAC_UPDATE),
    .UNDERRUN    (UNDERRUN),
    .CLR_UNDERRUN(CLR_UNDERRUN),
    .FIFO_LEVEL  (FIFO_LEVEL),
    .BUSY        (BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [7:0] s);
`ifdef DAC_SLEW_LIMIT_EN
    int c;
    int t;
    c = int'(cur);
    t = int'(s);
    if (t > c + STEP) t = c + STEP;
    else if (t < c - STEP) t = c - STEP;
    return 8'(t);
`else
    return s + 8'(0 * cur);
`endif
  endfunction

  // Reference model: samples held in a queue, phase flags, cycles-since-last-tick counter.
  logic [7:0] mq[$];
  bit         m_primed;
  bit         m_running;
  int         m_cnt;
  logic [7:0] m_code;
  bit         m_upd;
  bit         m_und;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_primed  = 0;
      m_running = 0;
      m_cnt     = 0;
      m_code    = 8'h00;
      m_upd     = 0;
      m_und     = 0;
    end else begin : model_step
      int sz;
      bit tick;
      bit was_run;
      sz      = mq.size();
      tick    = m_running && (m_cnt >= int'(RATE_DIV));
      was_run = m_running;
      m_upd   = 0;
      if (tick && sz > 0) begin
        m_code = model_next(m_code, mq.pop_front());
        m_upd  = 1;
      end
      if (tick && sz == 0) m_und = 1;
      else if (CLR_UNDERRUN) m_und = 0;
      if (S_VALID && sz < DEPTH) mq.push_back(S_DATA);
      if (!EN) begin
        m_primed  = 0;
        m_running = 0;
      end else if (!m_primed && !m_running) begin
        m_primed = 1;
      end else if (m_primed && sz > 0) begin
        m_primed  = 0;
        m_running = 1;
      end
      if (was_run && m_running) m_cnt = tick ? 0 : m_cnt + 1;
      else m_cnt = 0;
    end
  end

  always @(negedge CLK) begin
    chk("model_code", DAC_CODE, m_code);
    chk("model_update", DAC_UPDATE, m_upd);
    chk("model_underrun", UNDERRUN, m_und);
    chk("model_level", FIFO_LEVEL, mq.size());
    chk("model_ready", S_READY, mq.size() < DEPTH);
    chk("model_busy", BUSY, m_running);
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_update(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (DAC_UPDATE) begin
        at = i;
        break;
      end
      step();
    end
    if (at < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_code"}, DAC_CODE, 8'h00);
    chk({tag, "_update"}, DAC_UPDATE, 1'b0);
    chk({tag, "_underrun"}, UNDERRUN, 1'b0);
    chk({tag, "_level"}, FIFO_LEVEL, 4'd0);
    chk({tag, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_codes[3];
    int at;
    int since;
    exp_codes[0] = 8'h10;
    exp_codes[1] = 8'h20;
    exp_codes[2] = 8'h30;

    RST = 1'b1; EN = 1'b0; S_VALID = 1'b0; S_DATA = 8'h00; CLR_UNDERRUN = 1'b0;
    RATE_DIV = 16'd3;
    repeat (2) step();
    check_reset_outputs("reset");
    RST = 1'b0;
    step();
    chk("reset_ready", S_READY, 1'b1);

    // Three samples at RATE_DIV=3: one update every 4 cycles.
    EN = 1'b1; S_VALID = 1'b1;
    S_DATA = 8'h10; step();
    S_DATA = 8'h20; step();
    S_DATA = 8'h30; step();
    S_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_update("play", 20, at);
      chk("play_code", DAC_CODE, exp_codes[k]);
      chk("play_busy", BUSY, 1'b1);
      if (k == 0) chk("model_pin_code", m_code, 8'h10);
      if (k > 0) chk("play_spacing", at + 1, 4);
      step();
    end

    // Empty FIFO at the next tick.
    since = -1;
    for (int i = 0; i < 20; i++) begin
      if (UNDERRUN) begin since = i; break; end
      step();
    end
    chk("underrun_set", UNDERRUN, 1'b1);
    chk("underrun_code_held", DAC_CODE, 8'h30);
    chk("underrun_no_update", DAC_UPDATE, 1'b0);
    chk("underrun_busy", BUSY, 1'b1);
    CLR_UNDERRUN = 1'b1; step(); CLR_UNDERRUN = 1'b0;
    chk("underrun_cleared", UNDERRUN, 1'b0);

    // Fill to full while idle, then a tick pop coincides with a rejected push.
    EN = 1'b0; step();
    S_VALID = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      S_DATA = 8'(8'h80 + i);
      step();
    end
    S_VALID = 1'b0;
    chk("full_ready", S_READY, 1'b0);
    chk("full_level", FIFO_LEVEL, 4'd8);
    RATE_DIV = 16'd0; S_VALID = 1'b1; S_DATA = 8'hEE; EN = 1'b1;
    for (int i = 0; i < 10 && !BUSY; i++) step();
    chk("full_busy", BUSY, 1'b1);
    chk("full_ready_run", S_READY, 1'b0);
    step();
    chk("full_pop_level", FIFO_LEVEL, 4'd7);
    chk("full_pop_update", DAC_UPDATE, 1'b1);
    S_VALID = 1'b0;
    step(); step();
    RATE_DIV = 16'd1000;
    chk("five_left", FIFO_LEVEL, 4'd5);

    // Asynchronous reset mid-RUN.
    RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    RST = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("prime_busy", BUSY, 1'b0);
      chk("prime_update", DAC_UPDATE, 1'b0);
    end

    // Two equal samples from code 0: slew-limited steps or direct loads.
    RST = 1'b1; step(); RST = 1'b0;
    RATE_DIV = 16'd0; EN = 1'b1; S_VALID = 1'b1; S_DATA = 8'h40;
    step(); step();
    S_VALID = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_update("slew", 20, at);
`ifdef DAC_SLEW_LIMIT_EN
      chk("slew_code", DAC_CODE, (k == 0) ? 8'h10 : 8'h20);
`else
      chk("slew_code", DAC_CODE, 8'h40);
`endif
      step();
    end

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      int dens;
      dens = (i / 400) % 4;
      if (RST) RST = 1'b0;
      if ($urandom_range(0, EN ? 60 : 4) == 0) EN = ~EN;
      if ($urandom_range(0, 40) == 0) RATE_DIV = 16'($urandom_range(0, 5));
      S_VALID = ($urandom_range(0, 3) < dens);
      S_DATA = 8'($urandom);
      CLR_UNDERRUN = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) RST = 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
